// File: rtl/sphere_pkg.sv
// Shared types and constants for the S2 low-discrepancy point generator.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: Q16.16 type, ONE, CORDIC gain and atan table, FSM state enum, sign-extend helper.
package sphere_pkg;

  localparam int FRAC     = 16;
  localparam int CORDIC_N = 16;

  typedef logic signed [31:0] q16_t;

  localparam q16_t ONE = 32'sh0001_0000;

  // 1/An = 0.607253 in Q16.16; seeding x0 with it makes the rotated vector unit length.
  localparam q16_t CORDIC_GAIN = 32'sd39797;

  // pi/2 in Q16.16, used to scale the in-quadrant fraction of vdc1 into radians.
  localparam logic [31:0] HALF_PI_Q16 = 32'd102944;

  // atan(2^-i) in Q16.16 radians.
  localparam q16_t ATAN_TAB [0:CORDIC_N-1] = '{
    32'sd51472, 32'sd30386, 32'sd16055, 32'sd8150,
    32'sd4091,  32'sd2047,  32'sd1024,  32'sd512,
    32'sd256,   32'sd128,   32'sd64,    32'sd32,
    32'sd16,    32'sd8,     32'sd4,     32'sd2
  };

  typedef enum logic [3:0] {
    S_IDLE,
    S_VDC0,
    S_DIV0,
    S_VDC1,
    S_DIV1,
    S_SQRT,
    S_CORDIC,
    S_MUL,
    S_DONE
  } state_t;

  function automatic logic signed [63:0] sext64(input q16_t a);
    return {{32{a[31]}}, a};
  endfunction

endpackage

// File: rtl/vdc_unit.sv
// Radical inverse vdc(k,b) as unsigned Q0.16: digit loop then 16-step restoring divide.
// Latency: start -> done = digits(k,b) + 1 + 16 cycles; done is a one-cycle pulse.
// Backpressure: none; start is only honoured while idle, the caller must wait for done.
// Ports: clk, rst (async high), start, k[31:0], base[2:0] (2..5) in;
//        dividing (divide phase active), done (pulse), vdc[15:0] (valid with done) out.
module vdc_unit
  import sphere_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [31:0]     k,
  input  logic [2:0]      base,
  output logic            dividing,
  output logic            done,
  output logic [FRAC-1:0] vdc
);

  typedef enum logic [1:0] {U_IDLE, U_DIG, U_DIV} ust_t;

  ust_t        ust;
  logic [31:0] k_r;
  logic [2:0]  b_r;
  logic [63:0] num;
  logic [63:0] den;
  logic [63:0] rem;
  logic [3:0]  cnt;

  logic [31:0] q_d;
  logic [31:0] r_d;
  logic [64:0] rem2;

  // Small-constant divide: powers of two are shifts, 3 and 5 are constant dividers.
  always_comb begin
    q_d = '0;
    case (b_r)
      3'd2:    q_d = k_r >> 1;
      3'd3:    q_d = k_r / 32'd3;
      3'd4:    q_d = k_r >> 2;
      default: q_d = k_r / 32'd5;
    endcase
    r_d  = k_r - q_d * {29'd0, b_r};
    rem2 = {rem, 1'b0};
  end

  assign dividing = (ust == U_DIV);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ust  <= U_IDLE;
      k_r  <= '0;
      b_r  <= 3'd2;
      num  <= '0;
      den  <= 64'd1;
      rem  <= '0;
      cnt  <= '0;
      vdc  <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (ust)
        U_IDLE: begin
          if (start) begin
            k_r <= k;
            b_r <= base;
            num <= '0;
            den <= 64'd1;
            ust <= U_DIG;
          end
        end
        U_DIG: begin
          // Digits come out least-significant first, so accumulating num*b+r
          // mirrors them about the radix point; den tracks b^digits.
          if (k_r == '0) begin
            rem <= num;
            cnt <= '0;
            vdc <= '0;
            ust <= U_DIV;
          end else begin
            k_r <= q_d;
            num <= num * {61'd0, b_r} + {32'd0, r_d};
            den <= den * {61'd0, b_r};
          end
        end
        U_DIV: begin
          // num < den, so every quotient bit is fractional.
          if (rem2 >= {1'b0, den}) begin
            rem <= 64'(rem2 - {1'b0, den});
            vdc <= {vdc[FRAC-2:0], 1'b1};
          end else begin
            rem <= rem2[63:0];
            vdc <= {vdc[FRAC-2:0], 1'b0};
          end
          cnt <= cnt + 4'd1;
          if (cnt == 4'(FRAC - 1)) begin
            done <= 1'b1;
            ust  <= U_IDLE;
          end
        end
        default: ust <= U_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/sphere_fsm_32bit_simple_minimal.sv
// Halton-style point on the unit sphere: z=2*vdc(k,b0)-1, azimuth 2*pi*vdc(k,b1), Q16.16 out.
// Latency: start accept -> done is data dependent, at most 134 cycles (both bases 2, k=2^32-1).
// Backpressure: start is taken only while ready=1; requests while busy are dropped.
// Ports: clk, rst (async high), start, k_in[31:0], base_sel0/1[1:0] in;
//        result_x/y/z[31:0] Q16.16, done (one-cycle pulse), ready (high in IDLE) out.
module sphere_fsm_32bit_simple_minimal
  import sphere_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] k_in,
  input  logic [1:0]  base_sel0,
  input  logic [1:0]  base_sel1,
  output logic [31:0] result_x,
  output logic [31:0] result_y,
  output logic [31:0] result_z,
  output logic        done,
  output logic        ready
);

  state_t      state;
  logic [31:0] k_lat;
  logic [1:0]  sel1_lat;
  q16_t        cphi;
  logic [16:0] sq_res;
  logic [4:0]  sq_bit;
  logic [33:0] sq_v;
  q16_t        cx;
  q16_t        cy;
  q16_t        cz;
  logic [3:0]  ci;
  logic [1:0]  quad;

  logic            u_start;
  logic            u_div;
  logic            u_done;
  logic [31:0]     u_k;
  logic [2:0]      u_base;
  logic [FRAC-1:0] u_vdc;

  // The vdc unit is shared: first pass (b0) starts on accept straight from the
  // input pins, second pass (b1) starts the moment the first one reports done.
  assign u_start = (state == S_IDLE && ready && start) || (state == S_DIV0 && u_done);
  assign u_k     = (state == S_IDLE) ? k_in : k_lat;
  assign u_base  = (state == S_IDLE) ? ({1'b0, base_sel0} + 3'd2) : ({1'b0, sel1_lat} + 3'd2);

  vdc_unit u_vdc_unit (
    .clk      (clk),
    .rst      (rst),
    .start    (u_start),
    .k        (u_k),
    .base     (u_base),
    .dividing (u_div),
    .done     (u_done),
    .vdc      (u_vdc)
  );

  logic signed [63:0] cphi_sq;
  logic signed [63:0] s_full;
  logic signed [63:0] prod_x;
  logic signed [63:0] prod_y;
  logic [16:0]        s_clamp;
  logic [16:0]        sq_trial;
  logic [33:0]        sq_trial2;
  logic [31:0]        ang_u;
  q16_t               cos_f;
  q16_t               sin_f;
  q16_t               sphi_s;
  q16_t               cordic_dx;
  q16_t               cordic_dy;

  always_comb begin
    // s = 1 - cphi^2 with the Q32.32 square rounded back to Q16.16.
    cphi_sq = sext64(cphi) * sext64(cphi);
    s_full  = sext64(ONE) - ((cphi_sq + 64'sd32768) >>> FRAC);
    s_clamp = s_full[63] ? 17'd0 : 17'(s_full);

    sq_trial  = sq_res | (17'd1 << sq_bit);
    sq_trial2 = {17'd0, sq_trial} * {17'd0, sq_trial};

    // Low 14 bits of vdc1 are the fraction of a quarter turn.
    ang_u = {18'd0, u_vdc[13:0]} * HALF_PI_Q16;

    cordic_dx = cx >>> ci;
    cordic_dy = cy >>> ci;

    // Rotate the first-quadrant (cos, sin) by quad * 90 degrees.
    cos_f = cx;
    sin_f = cy;
    case (quad)
      2'd1:    begin cos_f = -cy; sin_f = cx;  end
      2'd2:    begin cos_f = -cx; sin_f = -cy; end
      2'd3:    begin cos_f = cy;  sin_f = -cx; end
      default: begin cos_f = cx;  sin_f = cy;  end
    endcase

    sphi_s = {15'd0, sq_res};
    prod_x = sext64(sphi_s) * sext64(cos_f);
    prod_y = sext64(sphi_s) * sext64(sin_f);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      ready    <= 1'b1;
      done     <= 1'b0;
      result_x <= '0;
      result_y <= '0;
      result_z <= '0;
      k_lat    <= '0;
      sel1_lat <= '0;
      cphi     <= '0;
      sq_res   <= '0;
      sq_bit   <= '0;
      sq_v     <= '0;
      cx       <= '0;
      cy       <= '0;
      cz       <= '0;
      ci       <= '0;
      quad     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ready && start) begin
            k_lat    <= k_in;
            sel1_lat <= base_sel1;
            ready    <= 1'b0;
            state    <= S_VDC0;
          end
        end
        S_VDC0: if (u_div) state <= S_DIV0;
        S_DIV0: begin
          if (u_done) begin
            cphi  <= q16_t'({15'd0, u_vdc, 1'b0}) - ONE;
            state <= S_VDC1;
          end
        end
        S_VDC1: if (u_div) state <= S_DIV1;
        S_DIV1: begin
          if (u_done) begin
            // sqrt(s<<16) yields sqrt(s) directly in Q16.16.
            sq_v   <= {1'b0, s_clamp, 16'd0};
            sq_res <= '0;
            sq_bit <= 5'd16;
            quad   <= u_vdc[15:14];
            cx     <= CORDIC_GAIN;
            cy     <= '0;
            cz     <= q16_t'(ang_u >> 14);
            ci     <= '0;
            state  <= S_SQRT;
          end
        end
        S_SQRT: begin
          if (sq_trial2 <= sq_v) sq_res <= sq_trial;
          sq_bit <= sq_bit - 5'd1;
          if (sq_bit == 5'd0) state <= S_CORDIC;
        end
        S_CORDIC: begin
          if (!cz[31]) begin
            cx <= cx - cordic_dy;
            cy <= cy + cordic_dx;
            cz <= cz - ATAN_TAB[ci];
          end else begin
            cx <= cx + cordic_dy;
            cy <= cy - cordic_dx;
            cz <= cz + ATAN_TAB[ci];
          end
          ci <= ci + 4'd1;
          if (ci == 4'(CORDIC_N - 1)) state <= S_MUL;
        end
        S_MUL: begin
          result_x <= 32'(prod_x >>> FRAC);
          result_y <= 32'(prod_y >>> FRAC);
          result_z <= cphi;
          done     <= 1'b1;
          state    <= S_DONE;
        end
        S_DONE: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sphere_fsm_32bit_simple_minimal.sv
// Self-checking bench for the S2 point generator: scoreboard of expected points.
// Latency: n/a.
// Backpressure: waits on ready before each request; every wait is cycle-bounded.
module tb_sphere_fsm_32bit_simple_minimal;

  localparam int  TOL     = 64;
  localparam int  MAX_LAT = 140;
  localparam real PI      = 3.14159265358979;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] k_in;
  logic [1:0]  base_sel0;
  logic [1:0]  base_sel1;
  logic [31:0] result_x;
  logic [31:0] result_y;
  logic [31:0] result_z;
  logic        done;
  logic        ready;

  always #5 clk = ~clk;

  sphere_fsm_32bit_simple_minimal dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .k_in      (k_in),
    .base_sel0 (base_sel0),
    .base_sel1 (base_sel1),
    .result_x  (result_x),
    .result_y  (result_y),
    .result_z  (result_z),
    .done      (done),
    .ready     (ready)
  );

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] z;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp, input int tol);
    longint d;
    n_vec++;
    d = longint'($signed(got)) - longint'($signed(exp));
    if (d < 0) d = -d;
    if (d > longint'(tol)) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (tol %0d)", tag, got, exp, tol);
    end
  endtask

  // Radical inverse floored to Q0.16.
  function automatic logic [15:0] vdc_q(input logic [31:0] k, input int b);
    longint unsigned num, den, kk, bb;
    num = 0; den = 1; kk = k; bb = longint'(b);
    while (kk != 0) begin
      num = num * bb + (kk % bb);
      den = den * bb;
      kk  = kk / bb;
    end
    return 16'((num << 16) / den);
  endfunction

  function automatic logic [31:0] to_q(input real r);
    return 32'($rtoi($floor(r * 65536.0 + 0.5)));
  endfunction

  function automatic exp_t model(input logic [31:0] k, input logic [1:0] s0, input logic [1:0] s1);
    real  c, s, sp, th;
    exp_t e;
    c  = 2.0 * real'(vdc_q(k, int'(s0) + 2)) / 65536.0 - 1.0;
    s  = 1.0 - c * c;
    if (s < 0.0) s = 0.0;
    sp = $sqrt(s);
    th = 2.0 * PI * real'(vdc_q(k, int'(s1) + 2)) / 65536.0;
    e.x = to_q(sp * $cos(th));
    e.y = to_q(sp * $sin(th));
    e.z = to_q(c);
    return e;
  endfunction

  function automatic exp_t mk(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    exp_t e;
    e.x = x; e.y = y; e.z = z;
    return e;
  endfunction

  // hold: cycles start stays high (hold>1 also pulses start mid-run);
  // abort_at: cycle after accept at which rst is pulsed, or -1.
  task automatic run_vec(input string tag, input logic [31:0] k, input logic [1:0] s0,
                         input logic [1:0] s1, input exp_t e, input int hold, input int abort_at);
    int   cyc;
    int   rdy_bad;
    int   extra;
    exp_t want;
    cyc = 0;
    while (!ready && cyc < 20) begin @(negedge clk); cyc++; end
    check_val({tag, ".ready_idle"}, 32'(ready), 32'd1, 0);
    k_in = k; base_sel0 = s0; base_sel1 = s1; start = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    check_val({tag, ".ready_drop"}, 32'(ready), 32'd0, 0);
    k_in = $urandom; base_sel0 = 2'($urandom); base_sel1 = 2'($urandom);
    cyc = 0; rdy_bad = 0;
    while (!done && cyc < 200 && cyc != abort_at) begin
      start = (cyc + 1 < hold) || (hold > 1 && cyc == 40);
      if (ready) rdy_bad++;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (cyc == abort_at) begin
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_val({tag, ".rst_ready"}, 32'(ready), 32'd1, 0);
      check_val({tag, ".rst_done"}, 32'(done), 32'd0, 0);
      check_val({tag, ".rst_x"}, result_x, 32'd0, 0);
      check_val({tag, ".rst_y"}, result_y, 32'd0, 0);
      check_val({tag, ".rst_z"}, result_z, 32'd0, 0);
      void'(sb.pop_back());
      extra = 0;
      for (int i = 0; i < 160; i++) begin
        @(negedge clk);
        if (done) extra++;
      end
      check_val({tag, ".no_done_after_abort"}, 32'(extra), 32'd0, 0);
    end else if (done) begin
      if (sb.size() == 0) begin
        check_val({tag, ".sb_underflow"}, 32'd0, 32'd1, 0);
      end else begin
        want = sb.pop_front();
        check_val({tag, ".x"}, result_x, want.x, TOL);
        check_val({tag, ".y"}, result_y, want.y, TOL);
        check_val({tag, ".z"}, result_z, want.z, TOL);
      end
      check_val({tag, ".latency_ok"}, 32'(cyc <= MAX_LAT), 32'd1, 0);
      check_val({tag, ".ready_busy"}, 32'(rdy_bad + int'(ready)), 32'd0, 0);
      @(negedge clk);
      check_val({tag, ".done_pulse"}, 32'(done), 32'd0, 0);
      check_val({tag, ".ready_after"}, 32'(ready), 32'd1, 0);
      if (hold > 1) begin
        extra = 0;
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          if (done) extra++;
        end
        check_val({tag, ".single_done"}, 32'(extra), 32'd0, 0);
      end
    end else begin
      check_val({tag, ".timeout"}, 32'(cyc), 32'(MAX_LAT), 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, applied %0d", n_vec);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rk;
    logic [1:0]  r0, r1;
    rst = 1'b1; start = 1'b0; k_in = '0; base_sel0 = '0; base_sel1 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_val("reset.ready", 32'(ready), 32'd1, 0);
    check_val("reset.done", 32'(done), 32'd0, 0);
    check_val("reset.x", result_x, 32'd0, 0);
    check_val("reset.y", result_y, 32'd0, 0);
    check_val("reset.z", result_z, 32'd0, 0);

    run_vec("k1", 32'd1, 2'd0, 2'd1, mk(32'hFFFF8000, 32'h0000DDB4, 32'h00000000), 1, -1);
    run_vec("k2", 32'd2, 2'd0, 2'd1, mk(32'hFFFF9126, 32'hFFFF4000, 32'hFFFF8000), 1, -1);
    run_vec("k3", 32'd3, 2'd0, 2'd1, mk(32'h0000A9D5, 32'h00008E82, 32'h00008000), 1, -1);
    run_vec("k0a", 32'd0, 2'd0, 2'd1, mk(32'h0, 32'h0, 32'hFFFF0000), 1, -1);
    run_vec("k0b", 32'd0, 2'd3, 2'd2, mk(32'h0, 32'h0, 32'hFFFF0000), 1, -1);
    run_vec("k1s00", 32'd1, 2'd0, 2'd0, mk(32'hFFFF0000, 32'h0, 32'h0), 1, -1);
    run_vec("hshake", 32'd5, 2'd1, 2'd2, model(32'd5, 2'd1, 2'd2), 3, -1);
    run_vec("abort", 32'd1, 2'd0, 2'd1, mk(32'hFFFF8000, 32'h0000DDB4, 32'h00000000), 1, 60);
    run_vec("k1again", 32'd1, 2'd0, 2'd1, mk(32'hFFFF8000, 32'h0000DDB4, 32'h00000000), 1, -1);
    run_vec("kmax", 32'hFFFF_FFFF, 2'd0, 2'd0, model(32'hFFFF_FFFF, 2'd0, 2'd0), 1, -1);
    run_vec("k5b5", 32'd123456, 2'd3, 2'd3, model(32'd123456, 2'd3, 2'd3), 1, -1);
    for (int i = 0; i < 6; i++) begin
      rk = $urandom;
      r0 = 2'($urandom);
      r1 = 2'($urandom);
      run_vec($sformatf("rnd%0d", i), rk, r0, r1, model(rk, r0, r1), 1, -1);
    end

    check_val("sb_drain", 32'(sb.size()), 32'd0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
